// File: rtl/fma_issue_pkg.sv
// Shared constants, state encoding and opcode decode for the FMA request sequencer.
package fma_issue_pkg;

  localparam logic [6:0] OP_FMADD  = 7'h43;
  localparam logic [6:0] OP_FMSUB  = 7'h47;
  localparam logic [6:0] OP_FNMSUB = 7'h4B;
  localparam logic [6:0] OP_FNMADD = 7'h4F;

  localparam logic [1:0] SEL_FMADD  = 2'b00;
  localparam logic [1:0] SEL_FMSUB  = 2'b01;
  localparam logic [1:0] SEL_FNMSUB = 2'b10;
  localparam logic [1:0] SEL_FNMADD = 2'b11;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] sel;
  } dec_t;

  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    d.legal = 1'b1;
    d.sel   = SEL_FMADD;
    case (op)
      OP_FMADD:  d.sel = SEL_FMADD;
      OP_FMSUB:  d.sel = SEL_FMSUB;
      OP_FNMSUB: d.sel = SEL_FNMSUB;
      OP_FNMADD: d.sel = SEL_FNMADD;
      default: begin
        d.legal = 1'b0;
        d.sel   = SEL_FMADD;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fma_issue.sv
// Sequences one R4-type FP request through the mul_adder core, with a RUN-cycle
// watchdog, and returns the result or an error over a valid/ready channel.
module fma_issue
  import fma_issue_pkg::*;
#(
  parameter int TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  output logic [1:0]  fma_sel,
  output logic        fma_rst,
  input  logic [31:0] fma_z,
  input  logic        fma_z_stb
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  dec_t          dec_s;
  logic          accept_s;
  logic          timeout_s;

  assign dec_s     = decode_op(req_op);
  assign accept_s  = req_ready & req_valid & ~flush;
  assign timeout_s = (cnt_r == CNT_LAST);

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = dec_s.legal ? ISSUE : RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: state_next_s = RUN;
      RUN: begin
        if (fma_z_stb || timeout_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = RUN;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // State, registered handshake/control outputs, operand latch and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      fma_rst    <= 1'b1;
      fma_a      <= 32'h0000_0000;
      fma_b      <= 32'h0000_0000;
      fma_c      <= 32'h0000_0000;
      fma_sel    <= 2'b00;
      resp_data  <= 32'h0000_0000;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_next_s;
      req_ready  <= (state_next_s == IDLE);
      busy       <= (state_next_s != IDLE);
      resp_valid <= (state_next_s == RESP);
      fma_rst    <= (state_next_s != RUN);

      if (accept_s) begin
        fma_a   <= req_rs1;
        fma_b   <= req_rs2;
        fma_c   <= req_rs3;
        fma_sel <= dec_s.sel;
        resp_rd <= req_rd;
        if (!dec_s.legal) begin
          resp_data <= CANON_NAN;
          resp_err  <= 1'b1;
        end
      end

      if (state_r == ISSUE) begin
        cnt_r <= '0;
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r + CW'(1);
      end

      // Strobes only count in RUN; a strobe in the last watchdog cycle wins.
      if (state_r == RUN && !flush) begin
        if (fma_z_stb) begin
          resp_data <= fma_z;
          resp_err  <= 1'b0;
        end else if (timeout_s) begin
          resp_data <= CANON_NAN;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fma_issue.sv
// Scoreboard bench for fma_issue: a stub core answers known operand sets, and a
// monitor pops expected responses whenever a response handshake occurs.
module tb_fma_issue;
  import fma_issue_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_op = 7'd0;
  logic [31:0] req_rs1 = 32'd0, req_rs2 = 32'd0, req_rs3 = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        busy;
  logic [31:0] fma_a, fma_b, fma_c;
  logic [1:0]  fma_sel;
  logic        fma_rst;
  logic [31:0] fma_z;
  logic        fma_z_stb;

  logic        stub_stb = 1'b0;
  logic        force_stb = 1'b0;
  int          stub_delay = 5;
  int          stub_cnt = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          watch_rst = 1'b0;
  int          rst_low_seen = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fma_issue #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_rd(req_rd),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err), .busy(busy),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_sel(fma_sel),
    .fma_rst(fma_rst), .fma_z(fma_z), .fma_z_stb(fma_z_stb)
  );

  // Stub core: knows results for two operand sets; strobes stub_delay cycles
  // after leaving reset (stub_delay of 0 means never).
  function automatic logic [31:0] stub_result(input logic [31:0] a, b, c, input logic [1:0] sel);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4040_0000) begin
      case (sel)
        2'b00:   return 32'h40A0_0000;
        2'b01:   return 32'hBF80_0000;
        2'b10:   return 32'h3F80_0000;
        default: return 32'hC0A0_0000;
      endcase
    end else if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000) begin
      case (sel)
        2'b00:   return 32'h40E0_0000;
        2'b01:   return 32'h40A0_0000;
        2'b10:   return 32'hC0A0_0000;
        default: return 32'hC0E0_0000;
      endcase
    end
    return 32'hDEAD_BEEF;
  endfunction

  assign fma_z     = stub_result(fma_a, fma_b, fma_c, fma_sel);
  assign fma_z_stb = stub_stb | force_stb;

  always @(posedge clk) begin
    if (fma_rst) begin
      stub_cnt <= 0;
      stub_stb <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      stub_stb <= (stub_delay != 0) && (stub_cnt == stub_delay - 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got data %h rd %0d err %0b expected none",
                 resp_data, resp_rd, resp_err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        if (e.lat >= 0) check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (watch_rst && fma_rst !== 1'b1) rst_low_seen++;
  end

  task automatic send(input logic [6:0] op, input logic [31:0] a, b, c, input logic [4:0] rd,
                      input bit expect_resp, input logic [31:0] edata, input logic eerr,
                      input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_wait: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = rd;
    if (expect_resp) begin
      e.data = edata; e.rd = rd; e.err = eerr; e.lat = lat; e.acc = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy || sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: got busy %0b pending %0d expected idle", busy, sbq.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fma_a", fma_a, 32'd0);
    check("rst_fma_sel", {30'd0, fma_sel}, 32'd0);
    check("rst_fma_rst", {31'd0, fma_rst}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Legal opcodes against the stub core.
    send(7'h43, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd1, 1'b1, 32'h40A0_0000, 1'b0, -1);
    wait_idle();
    send(7'h47, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd2, 1'b1, 32'hBF80_0000, 1'b0, -1);
    wait_idle();
    send(7'h4F, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd3, 1'b1, 32'hC0A0_0000, 1'b0, -1);
    wait_idle();
    send(7'h4B, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd4, 1'b1, 32'h3F80_0000, 1'b0, -1);
    wait_idle();
    send(7'h43, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd5, 1'b1, 32'h40E0_0000, 1'b0, -1);
    wait_idle();
    send(7'h4B, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd6, 1'b1, 32'hC0A0_0000, 1'b0, -1);
    wait_idle();

    // Illegal opcode: response in cycle T+1, core kept in reset.
    watch_rst = 1'b1;
    send(7'h33, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd7, 1'b1, CANON_NAN, 1'b1, 1);
    wait_idle();
    watch_rst = 1'b0;
    check("illegal_fma_rst_low_cycles", 32'(rst_low_seen), 32'd0);

    // Timeout: silent core, error response TIMEOUT+2 cycles after accept.
    stub_delay = 0;
    send(7'h43, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd9, 1'b1, CANON_NAN, 1'b1, TIMEOUT + 2);
    wait_idle();
    stub_delay = 5;

    // Backpressure: response held stable while resp_ready is low.
    resp_ready = 1'b0;
    send(7'h47, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 5'd17, 1'b1, 32'h40A0_0000, 1'b0, -1);
    begin
      int n;
      n = 0;
      while (!resp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", resp_data, 32'h40A0_0000);
      check("bp_rd", {27'd0, resp_rd}, 32'd17);
      check("bp_err", {31'd0, resp_err}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    wait_idle();

    // Flush in RUN, then a stale strobe: no response, back to IDLE.
    stub_delay = 40;
    send(7'h43, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd12, 1'b0, 32'd0, 1'b0, -1);
    begin
      int n;
      n = 0;
      while (fma_rst && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("flush_in_run", {31'd0, fma_rst}, 32'd0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("flush_fma_rst", {31'd0, fma_rst}, 32'd1);
    check("flush_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    force_stb = 1'b1;
    @(negedge clk);
    force_stb = 1'b0;
    @(negedge clk);
    check("stale_stb_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("stale_stb_busy", {31'd0, busy}, 32'd0);
    stub_delay = 5;
    send(7'h43, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'd13, 1'b1, 32'h40A0_0000, 1'b0, -1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
